// File: rtl/mcy_checker_pkg.sv
// Shared types and default constants for the lockstep mutation checker.
// Imported by the checker top and its priority encoder.
package mcy_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_RUN    = 3'd2,
        ST_PASS   = 3'd3,
        ST_FAIL   = 3'd4
    } state_e;

    localparam int DEF_NUM_CH     = 8;
    localparam int DEF_CH_WIDTH   = 32;
    localparam int DEF_WARMUP     = 4;
    localparam int DEF_HOLD       = 1;
    localparam int DEF_MAX_CYCLES = 1024;
    localparam int DEF_CNT_W      = 32;

    // Index width for an n-entry channel vector; never zero.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mcy_prio_enc.sv
// Lowest-index-first priority encoder with an any-set flag.
// Used to pick the reported channel when several mismatch at once.
module mcy_prio_enc #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        any_o = |req_i;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/mcy_lockstep_checker.sv
// Compares golden and mutated core channels in lockstep and reports
// pass, or fail with a record of the first mismatch of the failing streak.
module mcy_lockstep_checker
    import mcy_checker_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int CH_WIDTH   = DEF_CH_WIDTH,
    parameter int WARMUP     = DEF_WARMUP,
    parameter int HOLD       = DEF_HOLD,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [NUM_CH-1:0]            ch_mask_i,
    input  logic [NUM_CH-1:0]            ch_valid_i,
    input  logic [NUM_CH*CH_WIDTH-1:0]   golden_i,
    input  logic [NUM_CH*CH_WIDTH-1:0]   mutant_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         pass_o,
    output logic                         fail_o,
    output logic [idx_width(NUM_CH)-1:0] first_ch_o,
    output logic [CNT_W-1:0]             first_cycle_o,
    output logic [CH_WIDTH-1:0]          first_golden_o,
    output logic [CH_WIDTH-1:0]          first_mutant_o,
    output logic [NUM_CH-1:0]            mismatch_vec_o
);

    localparam int IDX_W  = idx_width(NUM_CH);
    localparam int HOLD_W = $clog2(HOLD + 1);

    localparam logic [CNT_W-1:0] WARM_LAST =
        (WARMUP > 0) ? CNT_W'(WARMUP - 1) : '0;
    localparam logic [CNT_W-1:0] RUN_LAST =
        CNT_W'(WARMUP + MAX_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

    generate
        if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
            $error("NUM_CH must be within 1..32");
        end
        if (HOLD < 1) begin : g_bad_hold
            $error("HOLD must be at least 1");
        end
        if (MAX_CYCLES < 1) begin : g_bad_max
            $error("MAX_CYCLES must be at least 1");
        end
        if ((longint'(MAX_CYCLES) + longint'(WARMUP))
            >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
            $error("CNT_W too narrow for WARMUP+MAX_CYCLES");
        end
    endgenerate

    state_e                state_q, state_d;
    logic [NUM_CH-1:0]     mask_q, mask_d;
    logic [NUM_CH-1:0]     vec_q, vec_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [IDX_W-1:0]      rch_q, rch_d;
    logic [CNT_W-1:0]      rcyc_q, rcyc_d;
    logic [CH_WIDTH-1:0]   rgold_q, rgold_d;
    logic [CH_WIDTH-1:0]   rmut_q, rmut_d;

    logic [NUM_CH-1:0]     raw_m;
    logic [IDX_W-1:0]      enc_idx;
    logic                  any_m;
    logic [CH_WIDTH-1:0]   sel_gold;
    logic [CH_WIDTH-1:0]   sel_mut;
    logic                  start_ok;
    logic                  in_warm;
    logic                  in_run;
    logic                  fail_hit;
    logic                  last_cyc;

    assign in_warm  = (state_q == ST_WARMUP);
    assign in_run   = (state_q == ST_RUN);
    assign start_ok = start_i && !abort_i &&
                      (state_q inside {ST_IDLE, ST_PASS, ST_FAIL});
    assign fail_hit = in_run && any_m && (hold_q == HOLD_LAST);
    assign last_cyc = (cnt_q == RUN_LAST);

    // Per-channel qualified mismatch: enabled, valid and differing.
    always_comb begin
        raw_m = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            raw_m[c] = mask_q[c] & ch_valid_i[c] &
                       (golden_i[c*CH_WIDTH +: CH_WIDTH] !=
                        mutant_i[c*CH_WIDTH +: CH_WIDTH]);
        end
    end

    mcy_prio_enc #(
        .N  (NUM_CH),
        .IW (IDX_W)
    ) u_prio_enc (
        .req_i (raw_m),
        .idx_o (enc_idx),
        .any_o (any_m)
    );

    // Route the encoder's chosen channel data to the capture record.
    always_comb begin
        sel_gold = '0;
        sel_mut  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (IDX_W'(c) == enc_idx) begin
                sel_gold = golden_i[c*CH_WIDTH +: CH_WIDTH];
                sel_mut  = mutant_i[c*CH_WIDTH +: CH_WIDTH];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; abort dominates everything, fail beats pass.
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (start_i) begin
                        state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
                    end
                end
                ST_WARMUP: begin
                    if (cnt_q == WARM_LAST) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fail_hit) begin
                        state_d = ST_FAIL;
                    end else if (last_cyc) begin
                        state_d = ST_PASS;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath next state: counters, sticky vector and first-mismatch record.
    always_comb begin
        mask_d  = mask_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        rch_d   = rch_q;
        rcyc_d  = rcyc_q;
        rgold_d = rgold_q;
        rmut_d  = rmut_q;
        if (abort_i || start_ok) begin
            mask_d  = abort_i ? '0 : ch_mask_i;
            vec_d   = '0;
            cnt_d   = '0;
            hold_d  = '0;
            rch_d   = '0;
            rcyc_d  = '0;
            rgold_d = '0;
            rmut_d  = '0;
        end else begin
            if (in_warm || in_run) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (in_run) begin
                vec_d  = vec_q | raw_m;
                hold_d = any_m ? hold_q + HOLD_W'(1) : '0;
                if (any_m && hold_q == '0) begin
                    rch_d   = enc_idx;
                    rcyc_d  = cnt_q;
                    rgold_d = sel_gold;
                    rmut_d  = sel_mut;
                end
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q  <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            rch_q   <= '0;
            rcyc_q  <= '0;
            rgold_q <= '0;
            rmut_q  <= '0;
        end else begin
            mask_q  <= mask_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            rch_q   <= rch_d;
            rcyc_q  <= rcyc_d;
            rgold_q <= rgold_d;
            rmut_q  <= rmut_d;
        end
    end

    // Outputs decoded from state; the record is visible only on fail.
    always_comb begin
        busy_o         = 1'b0;
        done_o         = 1'b0;
        pass_o         = 1'b0;
        fail_o         = 1'b0;
        first_ch_o     = '0;
        first_cycle_o  = '0;
        first_golden_o = '0;
        first_mutant_o = '0;
        mismatch_vec_o = vec_q;
        unique case (state_q)
            ST_WARMUP, ST_RUN: busy_o = 1'b1;
            ST_PASS: begin
                done_o = 1'b1;
                pass_o = 1'b1;
            end
            ST_FAIL: begin
                done_o         = 1'b1;
                fail_o         = 1'b1;
                first_ch_o     = rch_q;
                first_cycle_o  = rcyc_q;
                first_golden_o = rgold_q;
                first_mutant_o = rmut_q;
            end
            default: ;
        endcase
    end

endmodule
